alu_exec: RTL and testbench



---
 rtl/alu_exec.sv | 154 +++++++++++++++
 tb/tb_alu_exec.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// 8-bit execution unit: single-cycle logic/add/sub, 8-iteration shift-add multiply
// and restoring divide behind a start/busy/done handshake.
module alu_exec (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic        carry,
  output logic        dbz
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_DIV  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic [2:0]  op_q;
  logic [7:0]  a_q, b_q;
  logic [2:0]  cnt;
  logic [15:0] acc;
  logic [7:0]  rem, quo;

  logic        multi_cycle;
  logic [8:0]  sum9, diff9;
  logic [15:0] fast_res;
  logic        fast_carry, fast_dbz;
  logic [15:0] mul_add, acc_nx, run_res;
  logic [8:0]  div_trial;
  logic [7:0]  div_sub, rem_nx, quo_nx;
  logic        div_ge;
  logic        load_en, load_carry, load_dbz;
  logic [15:0] load_res;

  assign multi_cycle = (op == OP_MUL) || ((op == OP_DIV) && (b != 8'h00));

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = multi_cycle ? S_RUN : S_DONE;
      S_RUN:   if (cnt == 3'd7) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Single-cycle results come straight from the live operands on the capture edge.
  always_comb begin
    sum9       = {1'b0, a} + {1'b0, b};
    diff9      = {1'b0, a} - {1'b0, b};
    fast_res   = 16'h0000;
    fast_carry = 1'b0;
    fast_dbz   = 1'b0;
    case (op)
      OP_ADD:  begin fast_res = {7'b0, sum9};  fast_carry = sum9[8];  end
      OP_SUB:  begin fast_res = {7'b0, diff9}; fast_carry = diff9[8]; end
      OP_AND:  fast_res = {8'h00, a & b};
      OP_OR:   fast_res = {8'h00, a | b};
      OP_XOR:  fast_res = {8'h00, a ^ b};
      OP_DIV:  begin fast_res = {a, 8'hFF}; fast_dbz = 1'b1; end
      OP_PASS: fast_res = {8'h00, a};
      default: fast_res = {8'h00, a};
    endcase
  end

  // quo doubles as the dividend shift register: dividend bits leave at the top,
  // quotient bits enter at the bottom.
  always_comb begin
    mul_add   = b_q[cnt] ? ({8'h00, a_q} << cnt) : 16'h0000;
    acc_nx    = acc + mul_add;
    div_trial = {rem, quo[7]};
    div_ge    = (div_trial >= {1'b0, b_q});
    div_sub   = div_trial[7:0] - b_q;
    rem_nx    = div_ge ? div_sub : div_trial[7:0];
    quo_nx    = {quo[6:0], div_ge};
    run_res   = (op_q == OP_MUL) ? acc_nx : {rem_nx, quo_nx};
  end

  always_comb begin
    load_en    = 1'b0;
    load_res   = 16'h0000;
    load_carry = 1'b0;
    load_dbz   = 1'b0;
    if ((state == S_IDLE) && start && !multi_cycle) begin
      load_en    = 1'b1;
      load_res   = fast_res;
      load_carry = fast_carry;
      load_dbz   = fast_dbz;
    end else if ((state == S_RUN) && (cnt == 3'd7)) begin
      load_en  = 1'b1;
      load_res = run_res;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q   <= 3'd0;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      cnt    <= 3'd0;
      acc    <= 16'h0000;
      rem    <= 8'h00;
      quo    <= 8'h00;
      result <= 16'h0000;
      zero   <= 1'b0;
      carry  <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        op_q <= op;
        a_q  <= a;
        b_q  <= b;
        cnt  <= 3'd0;
        acc  <= 16'h0000;
        rem  <= 8'h00;
        quo  <= a;
      end else if (state == S_RUN) begin
        cnt <= cnt + 3'd1;
        acc <= acc_nx;
        rem <= rem_nx;
        quo <= quo_nx;
      end
      if (load_en) begin
        result <= load_res;
        zero   <= (load_res == 16'h0000);
        carry  <= load_carry;
        dbz    <= load_dbz;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed and random checks of alu_exec against an arithmetic reference model.
module tb_alu_exec;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [7:0]  a, b;
  logic [15:0] result;
  logic        busy, done, zero, carry, dbz;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .busy(busy), .done(done), .zero(zero), .carry(carry), .dbz(dbz)
  );

  always #5 clock = ~clock;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference: result, carry/borrow, divide-by-zero and cycles from accept to done.
  function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                output logic [15:0] r, output logic c, output logic d,
                                output int lat);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    r = 16'h0000; c = 1'b0; d = 1'b0; lat = 1;
    case (o)
      3'd0: begin r = 16'(xi + yi); c = (xi + yi) > 255; end
      3'd1: begin c = xi < yi; r = 16'((c ? 256 : 0) + ((xi - yi + 256) % 256)); end
      3'd2: r = {8'h00, x & y};
      3'd3: r = {8'h00, x | y};
      3'd4: r = {8'h00, x ^ y};
      3'd5: begin r = 16'(xi * yi); lat = 9; end
      3'd6: begin
        if (yi == 0) begin r = 16'(xi * 256 + 255); d = 1'b1; end
        else begin r = 16'((xi % yi) * 256 + xi / yi); lat = 9; end
      end
      default: r = {8'h00, x};
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] er, prev;
    logic ec, ed;
    int lat;
    model(o, x, y, er, ec, ed, lat);
    prev  = result;
    start = 1'b1; op = o; a = x; b = y;
    tick;
    start = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    for (int i = 1; i <= lat; i++) begin
      chk1("busy_run", busy, 1'b1);
      chk1("done_pulse", done, i == lat);
      if (i < lat) begin
        chk16("result_hold", result, prev);
        tick;
      end
    end
    chk16("result", result, er);
    chk1("zero", zero, er == 16'h0000);
    chk1("carry", carry, ec);
    chk1("dbz", dbz, ed);
    tick;
    chk1("busy_after", busy, 1'b0);
    chk1("done_after", done, 1'b0);
  endtask

  initial begin
    logic [7:0] x, y;
    logic [15:0] prod;
    logic saw_done;

    reset = 1'b1; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    tick; tick;
    reset = 1'b0;
    chk16("rst_result", result, 16'h0000);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_carry", carry, 1'b0);
    chk1("rst_dbz", dbz, 1'b0);

    do_op(3'd0, 8'hF0, 8'h20);
    do_op(3'd1, 8'h05, 8'h07);
    do_op(3'd4, 8'h5A, 8'h5A);
    do_op(3'd5, 8'hFF, 8'hFF);
    do_op(3'd5, 8'h00, 8'h37);
    do_op(3'd6, 8'd200, 8'd7);
    do_op(3'd6, 8'h35, 8'h00);
    do_op(3'd7, 8'hC3, 8'h11);
    do_op(3'd2, 8'hF0, 8'h3C);
    do_op(3'd3, 8'h81, 8'h18);

    // Start pulses during a multiply (including its done cycle) are dropped.
    x = 8'($urandom_range(1, 255));
    y = 8'($urandom_range(1, 255));
    prod = 16'(int'(x) * int'(y));
    start = 1'b1; op = 3'd5; a = x; b = y;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk1("ign_busy", busy, 1'b1);
      chk1("ign_done", done, c == 9);
      if (c == 9) chk16("ign_result", result, prod);
      start = (c == 3 || c == 9);
      op = 3'd0; a = 8'($urandom); b = 8'($urandom);
      tick;
    end
    start = 1'b0;
    chk1("ign_busy_end", busy, 1'b0);
    chk1("ign_done_end", done, 1'b0);
    chk16("ign_result_kept", result, prod);
    do_op(3'd0, 8'h12, 8'h34);

    // Reset in the middle of a divide aborts it with no done pulse.
    start = 1'b1; op = 3'd6; a = 8'd250; b = 8'd3;
    tick;
    start = 1'b0;
    tick; tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk16("abort_result", result, 16'h0000);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_zero", zero, 1'b0);
    chk1("abort_carry", carry, 1'b0);
    chk1("abort_dbz", dbz, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) saw_done = 1'b1;
      tick;
    end
    chk1("abort_no_done", saw_done, 1'b0);
    do_op(3'd0, 8'h01, 8'h01);

    // Reset and start on the same edge: reset wins and the start is lost.
    reset = 1'b1; start = 1'b1; op = 3'd0; a = 8'h10; b = 8'h10;
    tick;
    reset = 1'b0; start = 1'b0;
    chk1("rs_busy", busy, 1'b0);
    chk16("rs_result", result, 16'h0000);
    tick;
    chk1("rs_busy2", busy, 1'b0);
    chk1("rs_done2", done, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [2:0] ro;
      logic [7:0] ra, rb;
      ro = 3'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_op(ro, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
